// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, frame FSM with mid-bit sampling,
// sticky error flags and a first-word-fall-through receive FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line idle, waiting for a low level on rxs
// START    | half-bit wait, then confirm start bit (reject false start)
// DATA     | sample DATA_BITS bits at mid-bit, LSB first
// PARITY   | sample the parity bit and flag a mismatch
// STOP     | sample STOP_BITS stop bits; push frame on the last one
// BREAK    | framing error seen, wait for the line to return high
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic [DATA_BITS-1:0]          data_rx,
    output logic                          uart_valid,
    input  logic                          uart_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_frame,
    output logic                          err_parity,
    output logic                          err_overrun,
    input  logic                          err_clr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);
    localparam logic             ODD_PAR   = (PARITY == 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state_q, state_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic                 par_bad_q, par_bad_nxt;
    logic                 stop_cnt_q, stop_cnt_nxt;
    logic                 frame_done;
    logic                 frame_err;

    logic                 rx_meta;
    logic                 rxs;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_inc;
    logic [LVL_W-1:0]     level_q;
    logic                 pop;
    logic                 push_req;
    logic                 push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            shift_q    <= shift_nxt;
            par_bad_q  <= par_bad_nxt;
            stop_cnt_q <= stop_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        bit_cnt_nxt  = bit_cnt_q;
        shift_nxt    = shift_q;
        par_bad_nxt  = par_bad_q;
        stop_cnt_nxt = stop_cnt_q;
        frame_done   = 1'b0;
        frame_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    cnt_nxt   = HALF_BIT;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt     = FULL_BIT;
                        bit_cnt_nxt = '0;
                        par_bad_nxt = 1'b0;
                        state_nxt   = ST_DATA;
                    end
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_nxt   = {rxs, shift_q[DATA_BITS-1:1]};
                    bit_cnt_nxt = bit_cnt_q + 1'b1;
                    cnt_nxt     = FULL_BIT;
                    if (bit_cnt_q == LAST_DATA) begin
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    par_bad_nxt = ((^shift_q) ^ rxs) != ODD_PAR;
                    cnt_nxt     = FULL_BIT;
                    state_nxt   = ST_STOP;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (!rxs) begin
                        frame_err = 1'b1;
                        state_nxt = ST_BREAK;
                    end else if (stop_cnt_q == LAST_STOP) begin
                        // leave at mid-stop so the next start edge is caught early
                        frame_done = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                        cnt_nxt      = FULL_BIT;
                    end
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pop        = uart_valid && uart_ready;
    assign push_req   = frame_done && !par_bad_q;
    assign push_ok    = push_req && ((level_q != FULL_LVL) || pop);
    assign rd_ptr_inc = rd_ptr_q + 1'b1;
    assign uart_valid = (level_q != '0);
    assign fifo_level = level_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    // data_rx is registered so it can hold its last value once the FIFO drains
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_rx  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_inc;
            end
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (pop) begin
                if (level_q > LVL_W'(1)) begin
                    data_rx <= mem[rd_ptr_inc];
                end else if (push_ok) begin
                    data_rx <= shift_q;
                end
            end else if ((level_q == '0) && push_ok) begin
                data_rx <= shift_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= frame_err | (err_frame & ~err_clr);
            err_parity  <= (frame_done & par_bad_q) | (err_parity & ~err_clr);
            err_overrun <= (push_req & ~push_ok) | (err_overrun & ~err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: default 8N1, even-parity 8E1 and 7N2 instances.
module tb_uart_rx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx0, rx1, rx2;
    logic       ready0, ready1, ready2;
    logic       clr0, clr1, clr2;
    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic       valid0, valid1, valid2;
    logic [2:0] level0, level1, level2;
    logic       fe0, pe0, oe0, fe1, pe1, oe1, fe2, pe2, oe2;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int valid_cnt0 = 0;
    int vc;
    logic [8:0] q0[$], q1[$], q2[$];
    logic [8:0] e0, e1, e2;

    uart_rx_param u_dut0 (
        .clk(clk), .rst(rst), .uart_rx(rx0), .data_rx(data0), .uart_valid(valid0),
        .uart_ready(ready0), .fifo_level(level0), .err_frame(fe0), .err_parity(pe0),
        .err_overrun(oe0), .err_clr(clr0)
    );

    uart_rx_param #(.PARITY(2)) u_dut1 (
        .clk(clk), .rst(rst), .uart_rx(rx1), .data_rx(data1), .uart_valid(valid1),
        .uart_ready(ready1), .fifo_level(level1), .err_frame(fe1), .err_parity(pe1),
        .err_overrun(oe1), .err_clr(clr1)
    );

    uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .uart_rx(rx2), .data_rx(data2), .uart_valid(valid2),
        .uart_ready(ready2), .fifo_level(level2), .err_frame(fe2), .err_parity(pe2),
        .err_overrun(oe2), .err_clr(clr2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitors: a pop happens on the next rising edge whenever valid && ready here.
    always @(negedge clk) begin
        if (valid0) valid_cnt0++;
        if (valid0 && ready0) begin
            if (q0.size() == 0) begin
                chk_cnt++;
                $display("FAIL inst0 unexpected byte: got %0h, expected none", data0);
            end else begin
                e0 = q0.pop_front();
                check("inst0 data", 32'(data0), 32'(e0));
            end
        end
    end

    always @(negedge clk) begin
        if (valid1 && ready1) begin
            if (q1.size() == 0) begin
                chk_cnt++;
                $display("FAIL inst1 unexpected byte: got %0h, expected none", data1);
            end else begin
                e1 = q1.pop_front();
                check("inst1 data", 32'(data1), 32'(e1));
            end
        end
    end

    always @(negedge clk) begin
        if (valid2 && ready2) begin
            if (q2.size() == 0) begin
                chk_cnt++;
                $display("FAIL inst2 unexpected byte: got %0h, expected none", data2);
            end else begin
                e2 = q2.pop_front();
                check("inst2 data", 32'(data2), 32'(e2));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int inst, input logic v);
        case (inst)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // par_bit < 0 means no parity bit on the line
    task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                              input int par_bit, input logic stop_val, input int nstop);
        set_rx(inst, 1'b0);
        cyc(16);
        for (int i = 0; i < nbits; i++) begin
            set_rx(inst, data[i]);
            cyc(16);
        end
        if (par_bit >= 0) begin
            set_rx(inst, par_bit[0]);
            cyc(16);
        end
        for (int i = 0; i < nstop; i++) begin
            set_rx(inst, stop_val);
            cyc(16);
        end
        set_rx(inst, 1'b1);
    endtask

    task automatic pulse_clr0();
        clr0 = 1'b1;
        cyc(1);
        clr0 = 1'b0;
    endtask

    initial begin
        logic [7:0] t2_bytes [4];
        t2_bytes = '{8'h0F, 8'h96, 8'h0F, 8'h69};
        rst = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
        clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);

        check("reset valid", 32'(valid0), 32'd0);
        check("reset level", 32'(level0), 32'd0);
        check("reset data", 32'(data0), 32'd0);
        check("reset flags", 32'({fe0, pe0, oe0}), 32'd0);

        // single byte, consumer always ready
        vc = valid_cnt0;
        q0.push_back(9'h55);
        send_frame(0, 9'h55, 8, -1, 1'b1, 1);
        cyc(4);
        check("t1 valid cycles", 32'(valid_cnt0 - vc), 32'd1);
        check("t1 level", 32'(level0), 32'd0);
        check("t1 flags", 32'({fe0, pe0, oe0}), 32'd0);

        // fill FIFO, overrun, drain in order
        ready0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b0, t2_bytes[i]});
            send_frame(0, {1'b0, t2_bytes[i]}, 8, -1, 1'b1, 1);
            cyc(2);
        end
        check("t2 level full", 32'(level0), 32'd4);
        check("t2 head", 32'(data0), 32'h0F);
        send_frame(0, 9'h0A5, 8, -1, 1'b1, 1);
        cyc(2);
        check("t2 overrun", 32'(oe0), 32'd1);
        check("t2 level after overrun", 32'(level0), 32'd4);
        ready0 = 1'b1;
        cyc(8);
        check("t2 drained level", 32'(level0), 32'd0);
        check("t2 drained queue", 32'(q0.size()), 32'd0);
        pulse_clr0();
        check("t2 overrun cleared", 32'(oe0), 32'd0);

        // false start
        rx0 = 1'b0;
        cyc(4);
        rx0 = 1'b1;
        cyc(20);
        check("t3 flags", 32'({fe0, pe0, oe0}), 32'd0);
        check("t3 level", 32'(level0), 32'd0);
        q0.push_back(9'h3C);
        send_frame(0, 9'h3C, 8, -1, 1'b1, 1);
        cyc(4);
        check("t3 received", 32'(q0.size()), 32'd0);

        // framing error followed by a held-low line
        send_frame(0, 9'h33, 8, -1, 1'b0, 1);
        rx0 = 1'b0;
        cyc(40);
        rx0 = 1'b1;
        cyc(4);
        check("t4 err_frame", 32'(fe0), 32'd1);
        check("t4 no push", 32'(level0), 32'd0);
        check("t4 other flags", 32'({pe0, oe0}), 32'd0);
        q0.push_back(9'h5A);
        send_frame(0, 9'h5A, 8, -1, 1'b1, 1);
        cyc(4);
        check("t4 recovered", 32'(q0.size()), 32'd0);
        check("t4 last data", 32'(data0), 32'h5A);
        pulse_clr0();
        check("t4 err_frame cleared", 32'(fe0), 32'd0);

        // even parity: 0x07 has three ones, so the parity bit must be 1
        q1.push_back(9'h07);
        send_frame(1, 9'h07, 8, 1, 1'b1, 1);
        cyc(4);
        check("t5 parity good received", 32'(q1.size()), 32'd0);
        check("t5 parity good flag", 32'(pe1), 32'd0);
        send_frame(1, 9'h07, 8, 0, 1'b1, 1);
        cyc(4);
        check("t5 parity bad flag", 32'(pe1), 32'd1);
        check("t5 parity bad no push", 32'(level1), 32'd0);

        // 7 data bits, 2 stop bits
        q2.push_back(9'h41);
        send_frame(2, 9'h41, 7, -1, 1'b1, 2);
        cyc(4);
        check("t5 7n2 received", 32'(q2.size()), 32'd0);
        check("t5 7n2 flags", 32'({fe2, pe2, oe2}), 32'd0);

        // reset mid-frame with two bytes queued; these are never expected
        ready0 = 1'b0;
        send_frame(0, 9'h11, 8, -1, 1'b1, 1);
        cyc(2);
        send_frame(0, 9'h22, 8, -1, 1'b1, 1);
        cyc(2);
        check("t6 queued", 32'(level0), 32'd2);
        rx0 = 1'b0;
        cyc(16);
        rx0 = 1'b1; cyc(16);
        rx0 = 1'b0; cyc(16);
        rx0 = 1'b0; cyc(16);
        rx0 = 1'b0; cyc(8);
        rst = 1'b1;
        rx0 = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("t6 level", 32'(level0), 32'd0);
        check("t6 valid", 32'(valid0), 32'd0);
        check("t6 flags", 32'({fe0, pe0, oe0}), 32'd0);
        check("t6 inst1 parity flag", 32'(pe1), 32'd0);
        ready0 = 1'b1;
        cyc(200);
        check("t6 no stray byte", 32'(level0), 32'd0);
        q0.push_back(9'h0C3);
        send_frame(0, 9'h0C3, 8, -1, 1'b1, 1);
        cyc(4);
        check("t6 received", 32'(q0.size()), 32'd0);
        check("t6 data", 32'(data0), 32'hC3);

        cyc(4);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
